// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the Hamming (15,11) encoder.
// HAMENC_SECDED_EN widens the codeword by one overall-parity bit.
package hamming_pkg;

  localparam int unsigned DATA_W = 11;
  localparam int unsigned HAM_W  = 15;
  localparam int unsigned PAR_W  = 4;
  localparam int unsigned CNT_W  = 16;
`ifdef HAMENC_SECDED_EN
  localparam int unsigned CW_W   = 16;
`else
  localparam int unsigned CW_W   = 15;
`endif

  // Data bits covered by each parity group (bit i selects d[i]).
  localparam logic [DATA_W-1:0] P1 = 11'b101_0101_1011;
  localparam logic [DATA_W-1:0] P2 = 11'b110_0110_1101;
  localparam logic [DATA_W-1:0] P4 = 11'b111_1000_1110;
  localparam logic [DATA_W-1:0] P8 = 11'b111_1111_0000;

  // Data-to-position map: d0..d10 land on positions 3,5,6,7,9..15; parity on 1,2,4,8.
  function automatic logic [HAM_W-1:0] place_bits(input logic [DATA_W-1:0] d,
                                                  input logic [PAR_W-1:0]  p);
    return {d[10:4], p[3], d[3:1], p[2], d[0], p[1], p[0]};
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming parity generator: masked XOR-reduce of a data word.
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [PAR_W-1:0]  par_c
);

  assign par_c = {^(data & P8), ^(data & P4), ^(data & P2), ^(data & P1)};

endmodule

// File: rtl/hamming_encoder_pipe.sv
// Two-stage pipelined Hamming (15,11) encoder with valid/ready on both sides.
// Define HAMENC_SECDED_EN to append an overall parity bit (16-bit codeword).
module hamming_encoder_pipe
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CW_W-1:0]   out_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cw_count
);

  logic              v1;
  logic              v2;
  logic              rdy1;
  logic              rdy2;
  logic [DATA_W-1:0] data1;
  logic [PAR_W-1:0]  par1;
  logic [PAR_W-1:0]  par_c;
  logic [HAM_W-1:0]  ham_c;
  logic [CW_W-1:0]   cw_c;

  assign rdy2      = !v2 || out_ready;
  assign rdy1      = !v1 || rdy2;
  assign in_ready  = rdy1;
  assign out_valid = v2;

  hamming_parity_gen u_parity (
    .data  (in_data),
    .par_c (par_c)
  );

  assign ham_c = place_bits(data1, par1);

`ifdef HAMENC_SECDED_EN
  assign cw_c = {^ham_c, ham_c};
`else
  assign cw_c = ham_c;
`endif

  // Stage registers only load on their ready, so stalled contents stay put.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      data1    <= '0;
      par1     <= '0;
      out_cw   <= '0;
      cw_count <= '0;
    end else begin
      if (rdy1) begin
        v1 <= in_valid;
        if (in_valid) begin
          data1 <= in_data;
          par1  <= par_c;
        end
      end
      if (rdy2) begin
        v2 <= v1;
        if (v1) begin
          out_cw <= cw_c;
        end
      end
      if (v2 && out_ready) begin
        cw_count <= cw_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hamming_encoder_pipe.sv
// Bench for hamming_encoder_pipe: directed cases plus random traffic vs. a
// positional Hamming reference model and an in-order scoreboard.
module tb_hamming_encoder_pipe;
  import hamming_pkg::*;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   out_cw;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  cw_count;

  int total = 0;
  int bad   = 0;

  logic [CW_W-1:0]  q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             stall_pend = 1'b0;
  logic [CW_W-1:0]  held_cw = '0;
  int               run = 0;
  int               max_run = 0;
  int               cyc = 0;

`ifdef HAMENC_SECDED_EN
  localparam logic [CW_W-1:0] EXP_7FF = 16'hFFFF;
  localparam logic [CW_W-1:0] EXP_001 = 16'h8007;
  localparam logic [CW_W-1:0] EXP_400 = 16'hC08B;
`else
  localparam logic [CW_W-1:0] EXP_7FF = 15'h7FFF;
  localparam logic [CW_W-1:0] EXP_001 = 15'h0007;
  localparam logic [CW_W-1:0] EXP_400 = 15'h408B;
`endif

  hamming_encoder_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_cw    (out_cw),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cw_count  (cw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Generic Hamming construction: data fills non-power-of-two positions in order,
  // parity at 2^b covers every position whose index has bit b set.
  function automatic logic [CW_W-1:0] ref_cw(input logic [DATA_W-1:0] d);
    logic [15:0] c;
    logic        par;
    int          k;
    c = '0;
    k = 0;
    for (int pos = 1; pos <= 15; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      par = 1'b0;
      for (int pos = 1; pos <= 15; pos++)
        if (((pos >> b) & 1) == 1) par ^= c[pos-1];
      c[(1 << b) - 1] = par;
    end
`ifdef HAMENC_SECDED_EN
    c[15] = ^c[14:0];
`endif
    return c[CW_W-1:0];
  endfunction

  // Scoreboard: samples handshakes at negedge, before the edge that commits them.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_cnt    = '0;
      stall_pend = 1'b0;
      run        = 0;
    end else begin
      check("cw_count", 32'(cw_count), 32'(exp_cnt));
      if (stall_pend && out_valid) check("stall_hold", 32'(out_cw), 32'(held_cw));
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", 32'(1), 32'(0));
        else check("out_cw", 32'(out_cw), 32'(q.pop_front()));
        exp_cnt = exp_cnt + CNT_W'(1);
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      stall_pend = out_valid && !out_ready;
      held_cw    = out_cw;
      if (in_valid && in_ready) q.push_back(ref_cw(in_data));
    end
  end

  task automatic send(input logic [DATA_W-1:0] d);
    logic acc;
    int   n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((q.size() != 0 || out_valid) && n < 40);
    check("drain_empty", 32'(q.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [DATA_W-1:0] d,
                            input logic [CW_W-1:0] exp);
    int n;
    send(d);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check(tag, 32'(out_cw), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CNT_W-1:0] base;
    int acc;
    int c0;
    int seen;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_cw_count", 32'(cw_count), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_cw", 32'(out_cw), 32'(0));
    @(posedge clk); #1;

    // Two-cycle latency for a lone zero word.
    send(11'h000);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1", 32'(out_valid), 32'(0));
    @(negedge clk);
    check("lat_cycle2", 32'(out_valid), 32'(1));
    check("zero_cw", 32'(out_cw), 32'(0));
    @(negedge clk);
    check("cnt_after_one", 32'(cw_count), 32'(1));
    @(posedge clk); #1;

    check_word("cw_7ff", 11'h7FF, EXP_7FF);
    check_word("cw_001", 11'h001, EXP_001);
    check_word("cw_400", 11'h400, EXP_400);
    for (int i = 0; i < 11; i++) begin
      logic [DATA_W-1:0] oh;
      oh = DATA_W'(1) << i;
      check_word($sformatf("onehot_%0d", i), oh, ref_cw(oh));
    end

    // Back-to-back stream of 20 words.
    drain();
    base = exp_cnt;
    max_run = 0;
    c0 = cyc;
    for (int i = 0; i < 20; i++) send(DATA_W'($urandom));
    check("stream_rate", 32'(cyc - c0), 32'(20));
    drain();
    check("stream_cnt", 32'(cw_count), 32'(base + CNT_W'(20)));
    check("stream_run", 32'(max_run), 32'(20));

    // Backpressure: only two words fit while the output is blocked.
    base = exp_cnt;
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    repeat (5) begin
      in_data = DATA_W'($urandom);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    check("bp_accepts", 32'(acc), 32'(2));
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    drain();
    check("bp_count", 32'(cw_count), 32'(base + CNT_W'(2)));

    // Reset with both stages full drops the words.
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      in_data = DATA_W'($urandom);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_cw_count", 32'(cw_count), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_ghost", 32'(seen), 32'(0));
    @(posedge clk); #1;

    // Random traffic with random backpressure.
    repeat (400) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = DATA_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();
    check("final_cnt", 32'(cw_count), 32'(exp_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_encoder_pipe.md
Name: hamming_encoder_pipe

Overview:
- Pipelined Hamming (15,11) encoder; transmit-side counterpart of the pipelined decoder.
- Accepts 11-bit data words and emits 15-bit even-parity codewords with parity at positions 1, 2, 4 and 8.
- Two-stage pipeline with valid/ready backpressure on both sides; sits between the data source and the channel/decoder under test.

Parameters:
- DATA_W, 11, data word width (fixed by code; not for override).
- CW_W, 15, codeword width (16 when HAMENC_SECDED_EN is defined).
- CNT_W, 16, width of the emitted-codeword counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  data word d[10:0].
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  encoder accepts in_data this cycle.
- out_cw  out  CW_W  codeword; cw[i-1] holds Hamming position i.
- out_valid  out  1  out_cw is valid.
- out_ready  in  1  downstream accepts out_cw.
- cw_count  out  CNT_W  number of codewords handed off (out_valid & out_ready).

Behaviour:
- Bit mapping: data d0..d10 fill positions 3,5,6,7,9,10,11,12,13,14,15 in order. Parity bits use even parity:
  - p1 (pos1) = d0^d1^d3^d4^d6^d8^d10
  - p2 (pos2) = d0^d2^d3^d5^d6^d9^d10
  - p4 (pos4) = d1^d2^d3^d7^d8^d9^d10
  - p8 (pos8) = d4^d5^d6^d7^d8^d9^d10
- Stage 1 (v1): registers in_data and the four parity bits.
- Stage 2 (v2): registers the assembled codeword; out_cw and out_valid come straight from the stage-2 registers.
- Latency: 2 cycles from the accept edge to out_valid, with no stalls. Throughput: 1 word/cycle.
- Ready chain (combinational):
  - rdy2 = !v2 | out_ready
  - rdy1 = !v1 | rdy2
  - in_ready = rdy1
- Stage 1 loads when rdy1: v1 <= in_valid.
- Stage 2 loads when rdy2: v2 <= v1.
- Held data never changes while its valid bit is set and the stage is not advancing (stall-stable).
- A simultaneous drain and fill of the same stage in one cycle is legal; no bubble is inserted.
- in_data is ignored when in_valid=0. out_cw is don't-care when out_valid=0, but the bench checks it only under out_valid.
- cw_count increments on each out_valid & out_ready cycle and wraps modulo 2^CNT_W; there is no saturation.
- Reset values: v1=v2=0, out_valid=0, out_cw=0, cw_count=0, stage-1 data and parity registers=0.
  - in_ready reads 1 in the first cycle after reset.
  - Reset has priority over any handshake in the same cycle; words in flight are dropped and not counted.

Optional Feature:
- Macro: HAMENC_SECDED_EN.
- Defined: CW_W=16 and out_cw[15] = XOR of cw[14:0] (overall parity, SECDED). It is computed in stage 2, so latency is unchanged.
- Undefined: CW_W=15 and there is no overall parity bit.

Decomposition:
- Package hamming_pkg:
  - DATA_W, CW_W (under the macro)
  - the four parity-group masks as DATA_W-bit constants: P1=11'b101_0101_1011, P2=11'b110_0110_1101, P4=11'b111_1000_1110, P8=11'b111_1111_0000
  - the data-to-position map
- Sub-module hamming_parity_gen: combinational; masked XOR-reduce of the data word producing p[3:0]; instantiated in stage 1.

Test Plan:
- Reset, then in_data=11'h000 valid for one cycle with out_ready=1 -> out_valid 2 cycles later with out_cw=15'h0000; cw_count=1.
- in_data=11'h7FF -> out_cw=15'h7FFF. With HAMENC_SECDED_EN: 16'hFFFF.
- Single-bit data sweep:
  - 11'h001 -> 15'h0007 (SECDED: 16'h8007)
  - 11'h400 -> 15'h408B
  - all 11 one-hot words match the reference parity equations.
- Back-to-back stream of 20 words with out_ready=1 -> 20 codewords, in order, on consecutive cycles; cw_count=20.
- Backpressure: out_ready=0 for 5 cycles while in_valid stays 1 -> in_ready drops after 2 words are accepted; out_cw stays stable. After out_ready=1, there is no loss or duplication.
- Reset asserted while v1=v2=1 -> next cycle out_valid=0, cw_count=0, in_ready=1; the dropped words never appear.
